// File: rtl/neo_rtc_arb.sv
// uPD4990 RTC serial bus arbiter: mirrors the 68k control bits, or lets a host
// engine take the bus once the 68k is quiet and shift in a BCD time set.
module neo_rtc_arb #(
  parameter int HALF        = 4,
  parameter int IDLE_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        CPU_DIN,
  input  logic        CPU_CLK,
  input  logic        CPU_STROBE,
  input  logic        HOST_REQ,
  input  logic [39:0] HOST_TIME,
  output logic        RTC_DIN,
  output logic        RTC_CLK,
  output logic        RTC_STROBE,
  output logic        HOST_OWNS,
  output logic        BUSY,
  output logic        DONE
);

  localparam int CW = $clog2(HALF + 1);
  localparam int QW = $clog2(IDLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_BIT_LO, S_BIT_HI, S_STB, S_GAP, S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    bit_q, bit_d;
  logic [43:0]   shift_q, shift_d;
  logic          phase_q, phase_d;
  logic [QW-1:0] quiet_q, quiet_d;
  logic          din_q, din_d, clk_q, clk_d, stb_q, stb_d;
  logic          owns_q, owns_d, busy_q, busy_d, done_q, done_d;
  logic          half_end;

  assign half_end = (cnt_q == CW'(HALF - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    phase_d = phase_q;

    if (CPU_CLK || CPU_STROBE)               quiet_d = '0;
    else if (quiet_q == QW'(IDLE_CYCLES))    quiet_d = quiet_q;
    else                                     quiet_d = quiet_q + 1'b1;

    case (state_q)
      S_IDLE: if (HOST_REQ) begin
        shift_d = {4'h2, HOST_TIME};
        phase_d = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: if (quiet_q >= QW'(IDLE_CYCLES)) begin
        state_d = S_BIT_LO;
        cnt_d   = '0;
        bit_d   = '0;
      end
      S_BIT_LO: begin
        cnt_d = half_end ? '0 : cnt_q + 1'b1;
        if (half_end) state_d = S_BIT_HI;
      end
      S_BIT_HI: begin
        cnt_d = half_end ? '0 : cnt_q + 1'b1;
        if (half_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          state_d = (bit_q == (phase_q ? 6'd3 : 6'd43)) ? S_STB : S_BIT_LO;
        end
      end
      S_STB: begin
        cnt_d = half_end ? '0 : cnt_q + 1'b1;
        if (half_end) state_d = S_GAP;
      end
      S_GAP: begin
        cnt_d = half_end ? '0 : cnt_q + 1'b1;
        if (half_end) begin
          if (!phase_q) begin
            // Follow the time set with the hold/resume command (0).
            shift_d = '0;
            phase_d = 1'b1;
            bit_d   = '0;
            state_d = S_BIT_LO;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are a registered decode of the current state.
  always_comb begin
    din_d  = 1'b0;
    clk_d  = 1'b0;
    stb_d  = 1'b0;
    owns_d = (state_q != S_IDLE) && (state_q != S_WAIT);
    busy_d = (state_q != S_IDLE);
    done_d = (state_q == S_FIN);
    case (state_q)
      S_IDLE, S_WAIT: begin
        din_d = CPU_DIN;
        clk_d = CPU_CLK;
        stb_d = CPU_STROBE;
      end
      S_BIT_LO: din_d = shift_q[0];
      S_BIT_HI: begin
        din_d = shift_q[0];
        clk_d = 1'b1;
      end
      S_STB:   stb_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      phase_q <= 1'b0;
      quiet_q <= '0;
      din_q   <= 1'b0;
      clk_q   <= 1'b0;
      stb_q   <= 1'b0;
      owns_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      phase_q <= phase_d;
      quiet_q <= quiet_d;
      din_q   <= din_d;
      clk_q   <= clk_d;
      stb_q   <= stb_d;
      owns_q  <= owns_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign RTC_DIN    = din_q;
  assign RTC_CLK    = clk_q;
  assign RTC_STROBE = stb_q;
  assign HOST_OWNS  = owns_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_neo_rtc_arb.sv
// Bench for neo_rtc_arb: two configurations (HALF=4/IDLE=16 and HALF=1/IDLE=1)
// share stimulus and are checked every cycle against a waveform-level model.
module tb_neo_rtc_arb;

  logic        CLK = 1'b0, nRESET = 1'b0;
  logic        CPU_DIN = 1'b0, CPU_CLK = 1'b0, CPU_STROBE = 1'b0, HOST_REQ = 1'b0;
  logic [39:0] HOST_TIME = '0;
  logic [1:0]  din, rclk, stb, owns, busy, done;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int mmode[2], mk[2], mq[2];
  logic [47:0] mdat[2];
  int rise0, done0, req0;

  always #5 CLK = ~CLK;

  neo_rtc_arb #(.HALF(4), .IDLE_CYCLES(16)) u0 (
    .CLK(CLK), .nRESET(nRESET), .CPU_DIN(CPU_DIN), .CPU_CLK(CPU_CLK),
    .CPU_STROBE(CPU_STROBE), .HOST_REQ(HOST_REQ), .HOST_TIME(HOST_TIME),
    .RTC_DIN(din[0]), .RTC_CLK(rclk[0]), .RTC_STROBE(stb[0]),
    .HOST_OWNS(owns[0]), .BUSY(busy[0]), .DONE(done[0]));

  neo_rtc_arb #(.HALF(1), .IDLE_CYCLES(1)) u1 (
    .CLK(CLK), .nRESET(nRESET), .CPU_DIN(CPU_DIN), .CPU_CLK(CPU_CLK),
    .CPU_STROBE(CPU_STROBE), .HOST_REQ(HOST_REQ), .HOST_TIME(HOST_TIME),
    .RTC_DIN(din[1]), .RTC_CLK(rclk[1]), .RTC_STROBE(stb[1]),
    .HOST_OWNS(owns[1]), .BUSY(busy[1]), .DONE(done[1]));

  function automatic int hp(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int icy(int i);
    return (i == 0) ? 16 : 1;
  endfunction

  // {din,clk,stb} at owned cycle k: 44 bits + strobe + gap, then 4 bits + strobe + gap.
  function automatic logic [2:0] own_bus(int k, int h, logic [47:0] d);
    int j, base, nb, bi;
    if (k >= 100 * h) return 3'b000;
    if (k < 90 * h) begin j = k; base = 0; nb = 44; end
    else begin j = k - 90 * h; base = 44; nb = 4; end
    if (j < nb * 2 * h) begin
      bi = j / (2 * h);
      return {d[base + bi], ((j % (2 * h)) >= h), 1'b0};
    end
    if (j < nb * 2 * h + h) return 3'b001;
    return 3'b000;
  endfunction

  task automatic check(string tag, logic [5:0] got, logic [5:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d got=%b exp=%b (din,clk,stb,owns,busy,done)", tag, cyc, got, exp);
    end
  endtask

  task automatic check_int(string tag, int got, int exp);
    n_cmp++;
    assert (got == exp) else begin
      n_bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mmode[i] = 0; mk[i] = 0; mq[i] = 0; mdat[i] = '0;
    end
  endtask

  // One clock: predict each DUT's outputs for this edge, advance, then compare.
  task automatic step();
    logic [5:0] e[2];
    logic q;
    q = !CPU_CLK && !CPU_STROBE;
    for (int i = 0; i < 2; i++) begin
      case (mmode[i])
        0: begin
          e[i] = {CPU_DIN, CPU_CLK, CPU_STROBE, 3'b000};
          if (HOST_REQ) begin
            mmode[i] = 1;
            mdat[i]  = {4'h0, 4'h2, HOST_TIME};
          end
        end
        1: begin
          e[i] = {CPU_DIN, CPU_CLK, CPU_STROBE, 3'b010};
          if (mq[i] >= icy(i)) begin mmode[i] = 2; mk[i] = 0; end
        end
        default: begin
          e[i] = {own_bus(mk[i], hp(i), mdat[i]), 2'b11, logic'(mk[i] == 100 * hp(i))};
          mk[i]++;
          if (mk[i] > 100 * hp(i)) mmode[i] = 0;
        end
      endcase
      mq[i] = q ? ((mq[i] < icy(i)) ? mq[i] + 1 : mq[i]) : 0;
    end
    @(posedge CLK); #1; cyc++;
    check("u0", {din[0], rclk[0], stb[0], owns[0], busy[0], done[0]}, e[0]);
    check("u1", {din[1], rclk[1], stb[1], owns[1], busy[1], done[1]}, e[1]);
    if (owns[0] && rise0 < 0) rise0 = cyc;
    if (done[0] && done0 < 0) done0 = cyc;
  endtask

  task automatic pulse_req(logic [39:0] t);
    HOST_TIME = t;
    HOST_REQ  = 1'b1;
    step();
    HOST_REQ  = 1'b0;
  endtask

  task automatic cpu_set(logic d, logic c, logic s);
    CPU_DIN = d; CPU_CLK = c; CPU_STROBE = s;
  endtask

  initial begin
    model_reset();
    rise0 = -1; done0 = -1; req0 = 0;
    #3;
    check("rst_u0", {din[0], rclk[0], stb[0], owns[0], busy[0], done[0]}, 6'b0);
    check("rst_u1", {din[1], rclk[1], stb[1], owns[1], busy[1], done[1]}, 6'b0);
    @(posedge CLK); #1;
    nRESET = 1'b1;

    // Idle mirroring with random CPU bits.
    for (int j = 0; j < 30; j++) begin
      cpu_set(1'($urandom), 1'($urandom), 1'($urandom));
      step();
    end

    // Time set with a quiet 68k; later the CPU writes during ownership and a
    // second request arrives mid-transfer.
    cpu_set(0, 0, 0);
    for (int j = 0; j < 20; j++) step();
    rise0 = -1; done0 = -1;
    req0 = cyc + 1;
    pulse_req(40'h12_0315_2359);
    for (int j = 0; j < 60; j++) step();
    cpu_set(1, 0, 1);
    for (int j = 0; j < 90; j++) step();
    pulse_req({$urandom, $urandom});
    for (int j = 0; j < 60; j++) step();
    cpu_set(0, 0, 0);
    for (int j = 0; j < 280; j++) step();
    check_int("owns_rise_latency", rise0 - req0, 2);
    check_int("owned_cycles_thru_done", done0 - rise0 + 1, 401);

    // CPU_CLK toggling every 10 cycles holds off the start.
    pulse_req({$urandom, $urandom});
    for (int j = 0; j < 100; j++) begin
      cpu_set(1'($urandom), 1'((j / 10) % 2), 1'b0);
      step();
    end
    cpu_set(0, 0, 0);
    for (int j = 0; j < 480; j++) step();

    // Reset in the middle of phase A, then a fresh request.
    pulse_req({$urandom, $urandom});
    for (int j = 0; j < 150; j++) step();
    nRESET = 1'b0;
    #1;
    model_reset();
    check("arst_u0", {din[0], rclk[0], stb[0], owns[0], busy[0], done[0]}, 6'b0);
    check("arst_u1", {din[1], rclk[1], stb[1], owns[1], busy[1], done[1]}, 6'b0);
    @(posedge CLK); #1; cyc++;
    nRESET = 1'b1;
    for (int j = 0; j < 10; j++) step();
    pulse_req({$urandom, $urandom});
    for (int j = 0; j < 480; j++) step();

    // Random soak: sparse CPU activity and requests.
    for (int j = 0; j < 2500; j++) begin
      cpu_set(1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0));
      HOST_TIME = {$urandom, $urandom};
      HOST_REQ  = ($urandom_range(0, 149) == 0);
      step();
    end
    HOST_REQ = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
